// File: rtl/inc_arb_pkg.sv
// inc_arb_pkg: shared state encoding, default sizes and a one-hot helper
// for the round-robin incrementer arbiter.
package inc_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_NREQ      = 4;
  localparam int MAX_NREQ      = 8;

  // One-hot encode an index into the widest supported requester vector;
  // callers cast the result down to NREQ bits.
  function automatic logic [MAX_NREQ-1:0] onehot(input logic [2:0] idx);
    onehot = MAX_NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/inc.sv
// inc: the shared incrementer datapath; wraps at DATAWIDTH, no carry-out.
module inc #(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] a,
  output logic [DATAWIDTH-1:0] y
);

  assign y = a + DATAWIDTH'(1);

endmodule

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker. Returns the first set request
// bit found scanning upward from ptr, wrapping from NREQ-1 back to 0.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  winner
);

  logic [IDW-1:0] idx;

  // Scan from the far end towards ptr so the last hit is the closest one.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/inc_arbiter.sv
// inc_arbiter: shares one incrementer among NREQ requesters in round-robin
// order. Grant in one cycle, tagged registered result in the next.
// Build option: define INC_ARB_SAT_EN for a saturating increment
// (all-ones stays all-ones); otherwise the increment wraps to zero.
import inc_arb_pkg::*;

module inc_arbiter #(
  parameter  int DATAWIDTH = DEF_DATAWIDTH,
  parameter  int NREQ      = DEF_NREQ,
  localparam int IDW       = $clog2(NREQ)
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DATAWIDTH-1:0] a_in,
  output logic [NREQ-1:0]           gnt,
  output logic [DATAWIDTH-1:0]      d_out,
  output logic                      d_valid,
  output logic [IDW-1:0]            d_id,
  output logic                      d_ovf,
  output logic                      busy
);

  state_e                 state_q, state_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [IDW-1:0]         win_id_q, win_id_d;
  logic [DATAWIDTH-1:0]   op_reg_q, op_reg_d;
  logic [NREQ-1:0]        gnt_q, gnt_d;
  logic [DATAWIDTH-1:0]   d_out_q, d_out_d;
  logic                   d_valid_q, d_valid_d;
  logic [IDW-1:0]         d_id_q, d_id_d;
  logic                   d_ovf_q, d_ovf_d;
  logic                   busy_q, busy_d;

  logic                   pick_any;
  logic [IDW-1:0]         pick_win;
  logic [DATAWIDTH-1:0]   inc_y;
  logic [DATAWIDTH-1:0]   inc_res;
  logic                   op_all_ones;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .any    (pick_any),
    .winner (pick_win)
  );

  inc #(.DATAWIDTH(DATAWIDTH)) u_inc (
    .a (op_reg_q),
    .y (inc_y)
  );

  assign op_all_ones = &op_reg_q;

  // Post-incrementer result select: clamp at all-ones or let it wrap.
  always_comb begin
`ifdef INC_ARB_SAT_EN
    inc_res = op_all_ones ? {DATAWIDTH{1'b1}} : inc_y;
`else
    inc_res = inc_y;
`endif
  end

  // Next-state and output-register logic for the IDLE/BUSY controller.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_id_d  = win_id_q;
    op_reg_d  = op_reg_q;
    gnt_d     = gnt_q;
    d_out_d   = d_out_q;
    d_valid_d = 1'b0;
    d_id_d    = d_id_q;
    d_ovf_d   = d_ovf_q;
    busy_d    = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          op_reg_d = a_in[int'(pick_win)*DATAWIDTH +: DATAWIDTH];
          gnt_d    = NREQ'(onehot(3'(pick_win)));
          win_id_d = pick_win;
          busy_d   = 1'b1;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        d_out_d   = inc_res;
        d_ovf_d   = op_all_ones;
        d_id_d    = win_id_q;
        d_valid_d = 1'b1;
        gnt_d     = '0;
        busy_d    = 1'b0;
        ptr_d     = (int'(win_id_q) == NREQ - 1) ? '0 : win_id_q + IDW'(1);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any operation in flight.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      win_id_q  <= '0;
      op_reg_q  <= '0;
      gnt_q     <= '0;
      d_out_q   <= '0;
      d_valid_q <= 1'b0;
      d_id_q    <= '0;
      d_ovf_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_id_q  <= win_id_d;
      op_reg_q  <= op_reg_d;
      gnt_q     <= gnt_d;
      d_out_q   <= d_out_d;
      d_valid_q <= d_valid_d;
      d_id_q    <= d_id_d;
      d_ovf_q   <= d_ovf_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt     = gnt_q;
  assign d_out   = d_out_q;
  assign d_valid = d_valid_q;
  assign d_id    = d_id_q;
  assign d_ovf   = d_ovf_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_inc_arbiter.sv
// tb_inc_arbiter: directed scenarios plus a randomized run checked against
// a transaction-level round-robin model of the arbiter.
module tb_inc_arbiter;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [3:0]  req;
  logic [31:0] a_in;
  logic [3:0]  gnt;
  logic [7:0]  d_out;
  logic        d_valid;
  logic [1:0]  d_id;
  logic        d_ovf;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  inc_arbiter #(.DATAWIDTH(8), .NREQ(4)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .req     (req),
    .a_in    (a_in),
    .gnt     (gnt),
    .d_out   (d_out),
    .d_valid (d_valid),
    .d_id    (d_id),
    .d_ovf   (d_ovf),
    .busy    (busy)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] exp_inc(input logic [7:0] x);
`ifdef INC_ARB_SAT_EN
    return (x == 8'hFF) ? 8'hFF : x + 8'd1;
`else
    return x + 8'd1;
`endif
  endfunction

  // Reset applied and released on a falling edge.
  task automatic do_reset();
    req  = 4'b0;
    a_in = 32'b0;
    Rst  = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [16:0] obs;
    do_reset();
    obs = {gnt, d_out, d_valid, d_id, d_ovf, busy};
    n_tests++;
    if (obs !== 17'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want 0", obs);
    end
  endtask

  task automatic test_single();
    logic [16:0] obs;
    do_reset();
    a_in = 32'h0000_0041;
    req  = 4'b0001;
    @(negedge Clk);
    obs = {gnt, d_out, d_valid, d_id, d_ovf, busy};
    n_tests++;
    if (obs !== {4'b0001, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL single_grant: got %h", obs);
    end
    req = 4'b0000;
    @(negedge Clk);
    obs = {gnt, d_out, d_valid, d_id, d_ovf, busy};
    n_tests++;
    if (obs !== {4'b0000, 8'h42, 1'b1, 2'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL single_result: got %h want %h", obs, {4'b0000, 8'h42, 1'b1, 2'd0, 1'b0, 1'b0});
    end
    @(negedge Clk);
    n_tests++;
    if ({d_valid, d_out, gnt} !== {1'b0, 8'h42, 4'b0}) begin
      n_fail++;
      $display("FAIL single_pulse_end: d_valid=%b d_out=%h gnt=%b want 0/42/0", d_valid, d_out, gnt);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [16:0] obs;
    do_reset();
    a_in = 32'h0000_0010;
    req  = 4'b0001;
    @(negedge Clk);
    req = 4'b0000;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_busy: busy=%b want 1", busy);
    end
    Rst = 1'b1;
    #1;
    obs = {gnt, d_out, d_valid, d_id, d_ovf, busy};
    n_tests++;
    if (obs !== 17'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: got %h want 0", obs);
    end
    @(negedge Clk);
    Rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      n_tests++;
      if (d_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_no_valid: d_valid=%b want 0", d_valid);
      end
    end
    // With ptr back at 0, requesters 0 and 3 pick 0; ptr 1..3 would pick 3.
    req  = 4'b1001;
    a_in = 32'h0700_0003;
    @(negedge Clk);
    req = 4'b0000;
    n_tests++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_mid_ptr: gnt=%b want 0001", gnt);
    end
    @(negedge Clk);
  endtask

  task automatic test_all_held();
    logic [7:0] want_dout [5] = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h01};
    logic [1:0] want_id   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    a_in = 32'h3020_1000;
    req  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      n_tests++;
      if ({gnt, busy, d_valid} !== {4'b0001 << want_id[i], 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL all_held_gnt%0d: gnt=%b busy=%b dv=%b want gnt=%b", i, gnt, busy, d_valid, 4'b0001 << want_id[i]);
      end
      @(negedge Clk);
      n_tests++;
      if ({d_valid, d_id, d_out, gnt} !== {1'b1, want_id[i], want_dout[i], 4'b0}) begin
        n_fail++;
        $display("FAIL all_held_res%0d: dv=%b id=%0d dout=%h gnt=%b want id=%0d dout=%h", i, d_valid, d_id, d_out, gnt, want_id[i], want_dout[i]);
      end
    end
    req = 4'b0000;
    @(negedge Clk);
  endtask

  task automatic test_wrap();
    do_reset();
    a_in = 32'h0033_0000;
    req  = 4'b0100;
    @(negedge Clk);
    req  = 4'b0101;
    a_in = 32'h0060_0050;
    @(negedge Clk);
    n_tests++;
    if ({d_valid, d_id, d_out} !== {1'b1, 2'd2, 8'h34}) begin
      n_fail++;
      $display("FAIL wrap_first: dv=%b id=%0d dout=%h want 1/2/34", d_valid, d_id, d_out);
    end
    @(negedge Clk);
    n_tests++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_scan: gnt=%b want 0001", gnt);
    end
    @(negedge Clk);
    n_tests++;
    if ({d_valid, d_id, d_out} !== {1'b1, 2'd0, 8'h51}) begin
      n_fail++;
      $display("FAIL wrap_res0: dv=%b id=%0d dout=%h want 1/0/51", d_valid, d_id, d_out);
    end
    @(negedge Clk);
    req = 4'b0000;
    n_tests++;
    if (gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL wrap_then2: gnt=%b want 0100", gnt);
    end
    @(negedge Clk);
    n_tests++;
    if ({d_valid, d_id, d_out} !== {1'b1, 2'd2, 8'h61}) begin
      n_fail++;
      $display("FAIL wrap_res2: dv=%b id=%0d dout=%h want 1/2/61", d_valid, d_id, d_out);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] want;
`ifdef INC_ARB_SAT_EN
    want = 8'hFF;
`else
    want = 8'h00;
`endif
    do_reset();
    a_in = 32'h0000_FF00;
    req  = 4'b0010;
    @(negedge Clk);
    req = 4'b0000;
    @(negedge Clk);
    n_tests++;
    if ({d_valid, d_id, d_ovf, d_out} !== {1'b1, 2'd1, 1'b1, want}) begin
      n_fail++;
      $display("FAIL overflow: dv=%b id=%0d ovf=%b dout=%h want 1/1/1/%h", d_valid, d_id, d_ovf, d_out, want);
    end
  endtask

  task automatic test_operand_change();
    do_reset();
    a_in = 32'h0005_0000;
    req  = 4'b0100;
    @(negedge Clk);
    req  = 4'b0000;
    a_in = 32'h0077_0000;
    @(negedge Clk);
    n_tests++;
    if ({d_valid, d_id, d_ovf, d_out} !== {1'b1, 2'd2, 1'b0, 8'h06}) begin
      n_fail++;
      $display("FAIL operand_change: dv=%b id=%0d ovf=%b dout=%h want 1/2/0/06", d_valid, d_id, d_ovf, d_out);
    end
  endtask

  // Random traffic against a transaction model: an operation is either in
  // flight (granted, result due next edge) or not; the winner is the first
  // requester at or after the rotating start position.
  task automatic test_random();
    bit         m_inflight = 0;
    int         m_start    = 0;
    int         m_id       = 0;
    logic [7:0] m_op       = 0;
    logic [3:0] e_gnt      = 0;
    logic [7:0] e_dout     = 0;
    logic       e_dv       = 0;
    logic [1:0] e_id       = 0;
    logic       e_ovf      = 0;
    logic       e_busy     = 0;
    logic [7:0] ops [4];
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int r = 0; r < 4; r++) begin
        ops[r] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      end
      req  = ($urandom_range(0, 4) == 0) ? 4'b0 : 4'($urandom);
      a_in = {ops[3], ops[2], ops[1], ops[0]};
      if (m_inflight) begin
        e_dout     = exp_inc(m_op);
        e_ovf      = (m_op == 8'hFF);
        e_id       = 2'(m_id);
        e_dv       = 1'b1;
        e_gnt      = 4'b0;
        e_busy     = 1'b0;
        m_start    = (m_id + 1) % 4;
        m_inflight = 0;
      end else begin
        e_dv = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (!m_inflight && req[(m_start + k) % 4]) begin
            m_id       = (m_start + k) % 4;
            m_op       = ops[m_id];
            m_inflight = 1;
          end
        end
        e_gnt  = m_inflight ? (4'b0001 << m_id) : 4'b0;
        e_busy = m_inflight;
      end
      @(negedge Clk);
      n_tests++;
      if ({gnt, d_out, d_valid, d_id, d_ovf, busy} !== {e_gnt, e_dout, e_dv, e_id, e_ovf, e_busy}) begin
        n_fail++;
        $display("FAIL random_c%0d: gnt=%b dout=%h dv=%b id=%0d ovf=%b busy=%b want %b %h %b %0d %b %b",
                 cyc, gnt, d_out, d_valid, d_id, d_ovf, busy, e_gnt, e_dout, e_dv, e_id, e_ovf, e_busy);
      end
    end
    req = 4'b0;
  endtask

  initial begin
    Rst  = 1'b1;
    req  = 4'b0;
    a_in = 32'b0;
    test_reset();
    test_single();
    test_reset_mid_op();
    test_all_held();
    test_wrap();
    test_overflow();
    test_operand_change();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
